// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the HD44780 nibble writer (LCD_BUSY_POLL_EN adds read states)
package lcd_pkg;

  // Clock the delay constants are derived from
  localparam int LCD_FREQ = 50_000_000;

  // Bit of the 5-bit nibble command that carries RS
  localparam int RS_BIT = 4;

  // Width of the shared phase/delay counter
  localparam int CNT_W = 21;

  // Common execution delays in clock cycles
  localparam int T1US  = LCD_FREQ / 1_000_000;
  localparam int T10US = 10 * T1US;
  localparam int T53US = 53 * T1US;

  // Default bus-cycle timing in clock cycles at LCD_FREQ
  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_E_HIGH_CYC = 12;
  localparam int DEF_HOLD_CYC   = 2;

`ifdef LCD_BUSY_POLL_EN
  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_EHIGH, W_HOLD, WAIT, DONE,
    R_SETUP, R_EHIGH, R_HOLD, R_GAP
  } lcd_state_t;
`else
  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_EHIGH, W_HOLD, WAIT, DONE
  } lcd_state_t;
`endif

endpackage

// File: rtl/lcd_delay_counter.sv
// rtl/lcd_delay_counter.sv - loadable 21-bit down-counter with zero flag shared by all bus phases
module lcd_delay_counter
  import lcd_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load wins over counting; the counter parks at zero until reloaded
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// rtl/lcd_nibble_writer.sv - HD44780 4-bit bus cycle generator with execution delay (LCD_BUSY_POLL_EN enables BF polling)
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int FREQ       = 50_000_000,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int E_HIGH_CYC = DEF_E_HIGH_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int POLL_LIMIT = 1023
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             sendCommand,
  input  logic [4:0]       command,
  input  logic [CNT_W-1:0] commandDelay,
  input  logic             checkBusy,
  output logic             commandDone,
  output logic             commandTimeout,
  output logic             busy,
  inout  wire  [4:0]       LCD_D,
  output logic             LCD_E,
  output logic             LCD_RW
);

  // Counter reload values; each phase lasts N cycles so N-1 is loaded
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  lcd_state_t       state_q, state_d;
  logic [4:0]       cmd_q;
  logic [CNT_W-1:0] delay_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;
  logic             accept;

  // Frequency is informational only; cycle counts are passed in directly
  logic [31:0] unused_freq;
  assign unused_freq = FREQ;

  lcd_delay_counter u_delay_counter (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (cnt_load),
    .load_value (cnt_value),
    .zero       (cnt_zero)
  );

`ifdef LCD_BUSY_POLL_EN
  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

  logic           check_q;
  logic           nib_q;
  logic           bf_q;
  logic [PCW-1:0] poll_cnt_q;
  logic           timeout_q;
  logic           timeout_set;
  logic           pair_retry;
  logic           rw_d1_q;
  logic           drive_en;
`else
  logic [31:0] unused_poll_limit;
  logic        unused_check_busy;
  assign unused_poll_limit = POLL_LIMIT;
  assign unused_check_busy = checkBusy;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and counter reload for each phase entry
  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_value = '0;
    accept    = 1'b0;
`ifdef LCD_BUSY_POLL_EN
    timeout_set = 1'b0;
    pair_retry  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sendCommand) begin
          accept    = 1'b1;
          state_d   = W_SETUP;
          cnt_load  = 1'b1;
          cnt_value = SETUP_LD;
        end
      end
      W_SETUP: begin
        if (cnt_zero) begin
          state_d   = W_EHIGH;
          cnt_load  = 1'b1;
          cnt_value = EHIGH_LD;
        end
      end
      W_EHIGH: begin
        if (cnt_zero) begin
          state_d   = W_HOLD;
          cnt_load  = 1'b1;
          cnt_value = HOLD_LD;
        end
      end
      W_HOLD: begin
        if (cnt_zero) begin
`ifdef LCD_BUSY_POLL_EN
          if (check_q) begin
            state_d   = R_SETUP;
            cnt_load  = 1'b1;
            cnt_value = SETUP_LD;
          end else
`endif
          if (delay_q == '0) begin
            state_d = DONE;
          end else begin
            state_d   = WAIT;
            cnt_load  = 1'b1;
            cnt_value = delay_q - 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
`ifdef LCD_BUSY_POLL_EN
      R_SETUP: begin
        if (cnt_zero) begin
          state_d   = R_EHIGH;
          cnt_load  = 1'b1;
          cnt_value = EHIGH_LD;
        end
      end
      R_EHIGH: begin
        if (cnt_zero) begin
          state_d   = R_HOLD;
          cnt_load  = 1'b1;
          cnt_value = HOLD_LD;
        end
      end
      R_HOLD: begin
        if (cnt_zero) begin
          if (!nib_q) begin
            state_d   = R_SETUP;
            cnt_load  = 1'b1;
            cnt_value = SETUP_LD;
          end else if (!bf_q) begin
            state_d = DONE;
          end else if (poll_cnt_q == POLL_LAST) begin
            state_d     = DONE;
            timeout_set = 1'b1;
          end else begin
            state_d    = R_GAP;
            pair_retry = 1'b1;
            cnt_load   = 1'b1;
            cnt_value  = '0;
          end
        end
      end
      R_GAP: begin
        if (cnt_zero) begin
          state_d   = R_SETUP;
          cnt_load  = 1'b1;
          cnt_value = SETUP_LD;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Command and delay are captured once per transfer; the bus keeps the last command
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_q   <= '0;
      delay_q <= '0;
    end else if (accept) begin
      cmd_q   <= command;
      delay_q <= commandDelay;
    end
  end

  assign commandDone = (state_q == DONE);
  assign busy        = (state_q != IDLE) && (state_q != DONE);

`ifdef LCD_BUSY_POLL_EN
  // Busy-flag poll bookkeeping: nibble index, sampled BF, pair count, timeout
  always_ff @(posedge CLK) begin
    if (RESET) begin
      check_q    <= 1'b0;
      nib_q      <= 1'b0;
      bf_q       <= 1'b0;
      poll_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (accept) begin
        check_q    <= checkBusy;
        nib_q      <= 1'b0;
        poll_cnt_q <= '0;
        timeout_q  <= 1'b0;
      end
      if (state_q == R_EHIGH && cnt_zero && !nib_q) begin
        bf_q <= LCD_D[3];
      end
      if (state_q == R_HOLD && cnt_zero) begin
        nib_q <= ~nib_q;
      end
      if (pair_retry) begin
        poll_cnt_q <= poll_cnt_q + 1'b1;
      end
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Delayed RW so the data pins re-drive one cycle after the read ends
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rw_d1_q <= 1'b0;
    end else begin
      rw_d1_q <= LCD_RW;
    end
  end

  assign LCD_E  = (state_q == W_EHIGH) || (state_q == R_EHIGH);
  assign LCD_RW = (state_q == R_SETUP) || (state_q == R_EHIGH) ||
                  (state_q == R_HOLD)  || (state_q == R_GAP);
  assign drive_en       = !LCD_RW && !rw_d1_q;
  assign commandTimeout = commandDone && timeout_q;
  assign LCD_D[RS_BIT]  = LCD_RW ? 1'b0 : cmd_q[RS_BIT];
  assign LCD_D[3:0]     = drive_en ? cmd_q[3:0] : 4'bzzzz;
`else
  assign LCD_E          = (state_q == W_EHIGH);
  assign LCD_RW         = 1'b0;
  assign commandTimeout = 1'b0;
  assign LCD_D          = cmd_q;
`endif

endmodule
